prim_arbiter_rr_redundant: RTL and testbench
============================================

PRIM_ARBITER_RR_REDUNDANT -- requirements
Module: prim_arbiter_rr_redundant

Interface
REQ-001 Parameter N, 8, requester count, 2..32.
REQ-002 Parameter DW, 32, data width per requester.
REQ-003 Parameter Copies, 2, redundant arbiter copies, 2..4.
REQ-004 Parameter EnDataPort, 1, when 0 data_i is ignored and data_o is tied to 0.
REQ-005 Parameter LockIn, 1, when 1 a stalled grant is held until accepted.
REQ-006 Parameter MaskOnErr, 1, when 1 outputs are forced idle once err_o is set.
REQ-007 Localparam IdxW, $clog2(N), index width.
REQ-008 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-009 rst_ni  input  1  reset, synchronous to clk_i and active-low.
REQ-010 req_chk_i  input  1  enables request-stability checking; driven to 1 in normal operation.
REQ-011 req_i  input  N  request vector.
REQ-012 data_i  input  DW x N (unpacked)  per-requester data.
REQ-013 gnt_o  output  N  one-hot-or-zero grant.
REQ-014 idx_o  output  IdxW  granted index, 0 when idle.
REQ-015 valid_o  output  1  a grant is being offered.
REQ-016 data_o  output  DW  data of the granted requester, 0 when idle.
REQ-017 ready_i  input  1  downstream accepts when valid_o and ready_i are both 1.
REQ-018 mismatch_o  output  1  combinational current-cycle disagreement between copies.
REQ-019 err_o  output  1  sticky registered fault flag.

Function
REQ-020 Each copy shall receive req_i and data_i through its own prim_buf instance.
- Each copy holds an independent round-robin pointer register and lock register; no state is shared between copies.
REQ-021 Each copy shall grant the lowest-index requester strictly above its pointer.
- If there is no such requester, it shall wrap and grant the lowest-index active requester.
REQ-022 A copy's pointer shall update to the granted index only on the cycle in which valid_o and ready_i are both 1; otherwise it is held.
REQ-023 valid_o shall equal |req_i, combinationally, with zero-cycle latency from request to grant.
REQ-024 With LockIn=1, if valid_o=1 and ready_i=0, the copy shall register the granted index.
- The same grant is held on following cycles regardless of new higher-priority requests.
- The lock is released on acceptance, or when the locked requester drops its request (arbitration then proceeds normally that cycle).
REQ-025 With LockIn=0, the grant shall be recomputed every cycle.
REQ-026 gnt_o, idx_o, valid_o and data_o shall come from copy Copies-1.
REQ-027 mismatch_o shall be 1 when any copy's {valid,gnt,idx,data} differs from copy Copies-1.
REQ-028 mismatch_o shall also be 1 when any copy's gnt is not one-hot-or-zero, or when its valid differs from |gnt.
REQ-029 err_o shall be set on the clock edge following any cycle with mismatch_o=1 and shall remain 1 until reset.
REQ-030 With req_chk_i=1, LockIn=1 and a lock held, a locked requester dropping its request shall raise an assertion only; err_o is not affected.
REQ-031 With MaskOnErr=1 and err_o=1, gnt_o, valid_o, idx_o and data_o shall be 0 and all pointer updates shall be frozen.
REQ-032 With FixedArb-style behaviour not provided, all priority shall be round-robin; ties are impossible since the pointer is unique per copy.

Reset
REQ-033 While rst_ni=0 at a rising edge, every copy shall load pointer=N-1 (index 0 gets first priority) and clear its lock register, and err_q shall load 0.
REQ-034 Reset asserted mid-lock shall clear the lock and err_o on that edge; the first post-reset grant follows REQ-021 from pointer N-1.
REQ-035 During and after reset with req_i=0, outputs shall be gnt_o=0, idx_o=0, valid_o=0, data_o=0 and err_o=0.

Verification
REQ-036 N=4, req_i=4'b1111, ready_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3 and gnt_o one-hot each cycle.
REQ-037 LockIn=1, req_i=4'b0100 with ready_i=0, then req_i=4'b0101 for 3 cycles, then ready_i=1 -> idx_o=2 held for all 4 cycles, then idx_o=0 on the next cycle.
REQ-038 Force copy 0 gnt bit 1 for one cycle -> mismatch_o=1 that cycle, err_o=1 from the next edge and held, and outputs idle when MaskOnErr=1.
REQ-039 Accept idx 3 (pointer=3), then assert rst_ni=0 for one edge with req_i=4'b1001 -> first grant after reset is idx_o=0.
REQ-040 EnDataPort=0, req_i=4'b0010, data_i[1]=32'hDEADBEEF -> data_o=0 while valid_o=1 and idx_o=1.
REQ-041 Copies=3, random req_i/ready_i for 10k cycles without fault injection -> mismatch_o=0 and err_o=0 throughout, and every requester is granted within N acceptances.

Source files
------------

// File: rtl/prim_arbiter_rr_redundant.sv
// Redundant round-robin arbiter.
//
// Several independent copies of a round-robin arbiter run side by side, each
// fed through its own buffer so that a fault in one copy's input path or state
// shows up as a disagreement. The outputs come from the last copy. The copies
// are cross-checked every cycle, and any disagreement sets a sticky error flag.
//
// Parameters
//   N          requester count (2..32)
//   DW         data width per requester
//   Copies     number of redundant arbiter copies (2..4)
//   EnDataPort 0: data_i ignored, data_o tied to 0
//   LockIn     1: a stalled grant is held until it is accepted
//   MaskOnErr  1: outputs forced idle and pointers frozen once err_o is set
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset
//   req_chk_i   enables the request-stability assertion
//   req_i       request vector
//   data_i      per-requester data
//   gnt_o       one-hot-or-zero grant
//   idx_o       granted index (0 when idle)
//   valid_o     a grant is being offered
//   data_o      data of the granted requester (0 when idle)
//   ready_i     downstream accept (with valid_o)
//   mismatch_o  combinational disagreement between copies this cycle
//   err_o       sticky registered fault flag

module prim_buf #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in_i;
endmodule

module prim_arbiter_rr_redundant #(
  parameter int unsigned N          = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned Copies     = 2,
  parameter bit          EnDataPort = 1'b1,
  parameter bit          LockIn     = 1'b1,
  parameter bit          MaskOnErr  = 1'b1,
  localparam int unsigned IdxW      = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_chk_i,
  input  logic [N-1:0]    req_i,
  input  logic [DW-1:0]   data_i [N],
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  input  logic            ready_i,
  output logic            mismatch_o,
  output logic            err_o
);

  localparam int unsigned FlatW = N * DW + N;

  logic [FlatW-1:0] in_flat;
  logic             err_q, err_d;
  logic             freeze;

  logic [Copies-1:0]                valid_c;
  logic [Copies-1:0][N-1:0]         gnt_c;
  logic [Copies-1:0][IdxW-1:0]      idx_c;
  logic [Copies-1:0][DW-1:0]        data_c;

  // Requests and data share one flat bus so each copy needs a single buffer.
  always_comb begin
    in_flat = '0;
    in_flat[N-1:0] = req_i;
    for (int unsigned i = 0; i < N; i++) begin
      in_flat[N + i*DW +: DW] = data_i[i];
    end
  end

  assign freeze = MaskOnErr && err_q;

  for (genvar c = 0; c < Copies; c++) begin : g_copy
    logic [FlatW-1:0] buf_flat;
    logic [N-1:0]     req_b;
    logic [DW-1:0]    data_b [N];
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_found;
    logic [IdxW-1:0]  idx;
    logic             valid;
    logic [N-1:0]     gnt;
    logic [DW-1:0]    data;

    prim_buf #(.Width(FlatW)) u_buf (
      .in_i  (in_flat),
      .out_o (buf_flat)
    );

    always_comb begin
      req_b = buf_flat[N-1:0];
      for (int unsigned i = 0; i < N; i++) begin
        data_b[i] = buf_flat[N + i*DW +: DW];
      end
    end

    // First pass: lowest requester above the pointer; second pass wraps.
    always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (!arb_found && req_b[i] && (i > 32'(ptr_q))) begin
          arb_found = 1'b1;
          arb_idx   = IdxW'(i);
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!arb_found && req_b[i]) begin
          arb_found = 1'b1;
          arb_idx   = IdxW'(i);
        end
      end
    end

    // A held lock wins only while its requester is still asking.
    always_comb begin
      valid = |req_b;
      idx   = (lock_q && req_b[lock_idx_q]) ? lock_idx_q : arb_idx;
      data  = (EnDataPort && valid) ? data_b[idx] : '0;
    end

    // Continuous assignment so the grant can be overridden and restored cleanly.
    assign gnt = valid ? (N'(1) << idx) : '0;

    always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (!freeze) begin
        lock_d = 1'b0;
        if (valid && ready_i) begin
          ptr_d = idx;
        end else if (LockIn && valid) begin
          lock_d     = 1'b1;
          lock_idx_d = idx;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        ptr_q      <= IdxW'(N - 1);
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        ptr_q      <= ptr_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end

    if (LockIn) begin : g_req_chk
      // A requester holding a lock must keep requesting until accepted.
      req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_chk_i && lock_q) |-> req_b[lock_idx_q]);
    end

    assign valid_c[c] = valid;
    assign gnt_c[c]   = gnt;
    assign idx_c[c]   = idx;
    assign data_c[c]  = data;
  end

  always_comb begin
    mismatch_o = 1'b0;
    for (int unsigned c = 0; c < Copies; c++) begin
      if ((valid_c[c] != valid_c[Copies-1]) || (gnt_c[c] != gnt_c[Copies-1]) ||
          (idx_c[c] != idx_c[Copies-1]) || (data_c[c] != data_c[Copies-1])) begin
        mismatch_o = 1'b1;
      end
      if ((gnt_c[c] & (gnt_c[c] - N'(1))) != '0) begin
        mismatch_o = 1'b1;
      end
      if (valid_c[c] != (|gnt_c[c])) begin
        mismatch_o = 1'b1;
      end
    end
  end

  assign err_d = err_q | mismatch_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o   = err_q;
  assign valid_o = freeze ? 1'b0 : valid_c[Copies-1];
  assign gnt_o   = freeze ? '0   : gnt_c[Copies-1];
  assign idx_o   = freeze ? '0   : idx_c[Copies-1];
  assign data_o  = freeze ? '0   : data_c[Copies-1];

endmodule

// File: tb/tb_prim_arbiter_rr_redundant.sv
// Self-checking bench for prim_arbiter_rr_redundant (N=4).
// Main DUT: 3 copies with data port, lock-in and masking on error.
// Second DUT: 2 copies with the data port disabled.

module tb_prim_arbiter_rr_redundant;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_chk_i;
  logic [3:0]  req_i;
  logic [31:0] data_i [4];
  logic        ready_i;

  logic [3:0]  gnt_o, gnt_nd;
  logic [1:0]  idx_o, idx_nd;
  logic        valid_o, valid_nd;
  logic [31:0] data_o, data_nd;
  logic        mismatch_o, mismatch_nd;
  logic        err_o, err_nd;

  int checks = 0;
  int errors = 0;

  // Reference model state: rotating priority pointer, optional held grant, sticky error.
  int m_ptr;
  bit m_lock;
  int m_lidx;
  bit m_err;

  always #5 clk = ~clk;

  prim_arbiter_rr_redundant #(
    .N(4), .DW(32), .Copies(3), .EnDataPort(1'b1), .LockIn(1'b1), .MaskOnErr(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_chk_i(req_chk_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .idx_o(idx_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .mismatch_o(mismatch_o), .err_o(err_o)
  );

  prim_arbiter_rr_redundant #(
    .N(4), .DW(32), .Copies(2), .EnDataPort(1'b0), .LockIn(1'b1), .MaskOnErr(1'b1)
  ) dut_nd (
    .clk_i(clk), .rst_ni(rst_ni), .req_chk_i(req_chk_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_nd), .idx_o(idx_nd), .valid_o(valid_nd), .data_o(data_nd), .ready_i(ready_i),
    .mismatch_o(mismatch_nd), .err_o(err_nd)
  );

  function automatic void m_reset();
    m_ptr  = N - 1;
    m_lock = 1'b0;
    m_lidx = 0;
    m_err  = 1'b0;
  endfunction

  // Scan the ring starting just after the pointer; a live lock takes precedence.
  function automatic int m_pick(logic [3:0] r);
    if (m_lock && r[m_lidx]) return m_lidx;
    for (int k = 1; k <= N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic void m_update(logic [3:0] r, logic rdy);
    int g;
    if (m_err) return;
    g = m_pick(r);
    m_lock = 1'b0;
    if (r != 4'b0000) begin
      if (rdy) m_ptr = g;
      else begin
        m_lock = 1'b1;
        m_lidx = g;
      end
    end
  endfunction

  task automatic do_reset();
    rst_ni  = 1'b0;
    req_i   = 4'b0000;
    ready_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    req_chk_i = 1'b1;
    req_i     = 4'b0000;
    ready_i   = 1'b0;
    for (int i = 0; i < 4; i++) data_i[i] = 32'hA5A5_0000 + i;
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      #1;
      checks++;
      if (gnt_o !== 4'b0 || idx_o !== 2'd0 || valid_o !== 1'b0 || data_o !== 32'd0 ||
          err_o !== 1'b0 || mismatch_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle phase %0d got gnt=%b idx=%0d valid=%b data=%h err=%b mis=%b exp all 0",
                 p, gnt_o, idx_o, valid_o, data_o, err_o, mismatch_o);
      end
      rst_ni = 1'b1;
      m_reset();
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_i   = 4'b1111;
      ready_i = 1'b1;
      #1;
      checks++;
      if (idx_o !== 2'(i % 4) || gnt_o !== (4'b0001 << (i % 4)) || valid_o !== 1'b1 ||
          data_o !== data_i[i % 4]) begin
        errors++;
        $display("FAIL rr_seq cycle %0d got idx=%0d gnt=%b valid=%b data=%h exp idx=%0d",
                 i, idx_o, gnt_o, valid_o, data_o, i % 4);
      end
      m_update(req_i, ready_i);
      @(negedge clk);
    end
  endtask

  task automatic test_lock_in();
    logic [3:0] rq  [6];
    logic       rdy [6];
    int         ex  [6];
    rq  = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ex  = '{2, 2, 2, 2, 2, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_i   = rq[i];
      ready_i = rdy[i];
      #1;
      checks++;
      if (idx_o !== 2'(ex[i]) || valid_o !== 1'b1 || gnt_o !== (4'b0001 << ex[i])) begin
        errors++;
        $display("FAIL lock_hold cycle %0d got idx=%0d gnt=%b valid=%b exp idx=%0d",
                 i, idx_o, gnt_o, valid_o, ex[i]);
      end
      m_update(req_i, ready_i);
      @(negedge clk);
    end
  endtask

  task automatic test_data_port();
    do_reset();
    data_i[1] = 32'hDEADBEEF;
    req_i     = 4'b0010;
    ready_i   = 1'b1;
    #1;
    checks++;
    if (valid_nd !== 1'b1 || idx_nd !== 2'd1 || gnt_nd !== 4'b0010 || data_nd !== 32'd0) begin
      errors++;
      $display("FAIL nodata_port got valid=%b idx=%0d gnt=%b data=%h exp 1/1/0010/0",
               valid_nd, idx_nd, gnt_nd, data_nd);
    end
    checks++;
    if (data_o !== 32'hDEADBEEF || idx_o !== 2'd1) begin
      errors++;
      $display("FAIL data_port got data=%h idx=%0d exp deadbeef/1", data_o, idx_o);
    end
    m_update(req_i, ready_i);
    @(negedge clk);
  endtask

  task automatic test_random();
    int pend [4];
    int e_idx;
    bit e_valid;
    do_reset();
    req_chk_i = 1'b0;  // requesters drop freely here, including while locked
    for (int i = 0; i < 4; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req_i   = 4'($urandom_range(0, 15));
      ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) data_i[i] = $urandom;
      #1;
      e_valid = (req_i != 4'b0000);
      e_idx   = e_valid ? m_pick(req_i) : 0;
      checks++;
      if (valid_o !== e_valid || idx_o !== 2'(e_idx) ||
          gnt_o !== (e_valid ? (4'b0001 << e_idx) : 4'b0000) ||
          data_o !== (e_valid ? data_i[e_idx] : 32'd0)) begin
        errors++;
        $display("FAIL rand_grant cycle %0d req=%b rdy=%b got valid=%b idx=%0d gnt=%b exp valid=%b idx=%0d",
                 cyc, req_i, ready_i, valid_o, idx_o, gnt_o, e_valid, e_idx);
      end
      checks++;
      if (mismatch_o !== 1'b0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_noerr cycle %0d got mis=%b err=%b exp 0/0", cyc, mismatch_o, err_o);
      end
      if (valid_o === 1'b1 && ready_i) begin
        for (int i = 0; i < 4; i++) begin
          if (!req_i[i] || idx_o == 2'(i)) pend[i] = 0;
          else pend[i]++;
          if (pend[i] > N - 1) begin
            checks++;
            errors++;
            $display("FAIL starvation cycle %0d req %0d waited %0d acceptances exp <= %0d",
                     cyc, i, pend[i], N - 1);
            pend[i] = 0;
          end
        end
        checks++;
      end else begin
        for (int i = 0; i < 4; i++) if (!req_i[i]) pend[i] = 0;
      end
      m_update(req_i, ready_i);
      @(negedge clk);
    end
    req_chk_i = 1'b1;
  endtask

  task automatic test_reset_mid_lock();
    logic [3:0] pre [3];
    logic       prd [3];
    pre = '{4'b1000, 4'b1000, 4'b0001};
    prd = '{1'b0, 1'b1, 1'b1};
    // 0: lock on 3 then reset; 1: accept 3 then reset; 2: accept 0 then reset
    for (int s = 0; s < 3; s++) begin
      do_reset();
      req_i   = pre[s];
      ready_i = prd[s];
      @(negedge clk);
      rst_ni  = 1'b0;
      req_i   = 4'b1001;
      ready_i = 1'b0;
      @(negedge clk);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      #1;
      checks++;
      if (idx_o !== 2'd0 || valid_o !== 1'b1 || gnt_o !== 4'b0001 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_grant scen %0d got idx=%0d valid=%b gnt=%b err=%b exp 0/1/0001/0",
                 s, idx_o, valid_o, gnt_o, err_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fault();
    do_reset();
    req_i     = 4'b0001;
    ready_i   = 1'b1;
    data_i[0] = 32'h1234_5678;
    force dut.g_copy[0].gnt = 4'b0011;
    #1;
    checks++;
    if (mismatch_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_detect got mis=%b err=%b exp 1/0", mismatch_o, err_o);
    end
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 2'd0 || gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL fault_outputs got valid=%b idx=%0d gnt=%b exp 1/0/0001", valid_o, idx_o, gnt_o);
    end
    @(negedge clk);
    release dut.g_copy[0].gnt;
    for (int i = 0; i < 3; i++) begin
      req_i = (i == 0) ? 4'b1111 : 4'b0110;
      #1;
      checks++;
      if (err_o !== 1'b1 || valid_o !== 1'b0 || gnt_o !== 4'b0 || idx_o !== 2'd0 ||
          data_o !== 32'd0 || mismatch_o !== 1'b0) begin
        errors++;
        $display("FAIL err_sticky_mask cycle %0d got err=%b valid=%b gnt=%b idx=%0d data=%h mis=%b exp 1/0/0/0/0/0",
                 i, err_o, valid_o, gnt_o, idx_o, data_o, mismatch_o);
      end
      @(negedge clk);
    end
    do_reset();
    req_i   = 4'b0001;
    ready_i = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0 || valid_o !== 1'b1 || idx_o !== 2'd0 || data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL err_cleared got err=%b valid=%b idx=%0d data=%h exp 0/1/0/12345678",
               err_o, valid_o, idx_o, data_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_in();
    test_data_port();
    test_random();
    test_reset_mid_lock();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
